// File: rtl/tomasulo_pkg.sv
// -----------------------------------------------------------------------------
// tomasulo_pkg
// Shared definitions for the Tomasulo datapath functional units.
//   - Operation encoding for the mul/div unit (OP_MUL / OP_DIV).
//   - Default operand and tag widths.
//   - Handshake FSM state encoding and its enumerated type.
//   - max_int(): helper used to size latency counters.
// -----------------------------------------------------------------------------
package tomasulo_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_TAG_W = 3;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_EXEC_ENC = 2'd1;
  localparam logic [1:0] ST_WAIT_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = ST_IDLE_ENC,
    ST_EXEC     = ST_EXEC_ENC,
    ST_WAIT_CDB = ST_WAIT_ENC
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// -----------------------------------------------------------------------------
// muldiv_core
// Combinational unsigned multiply / divide datapath. Kept separate from the
// handshake FSM so a pipelined or iterative core can be swapped in later.
// Ports:
//   i_op      : 0 = multiply, 1 = divide
//   i_a, i_b  : operands (dividend, divisor)
//   o_result  : low WIDTH bits of a*b, or truncating a/b (all ones if b==0)
//   o_div0    : divide with a zero divisor
// -----------------------------------------------------------------------------
module muldiv_core
  import tomasulo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_div0
);

  logic [WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quot;
  logic             w_b_zero;

  // Product is evaluated at WIDTH bits, so overflow drops off the top.
  assign w_prod   = i_a * i_b;
  assign w_b_zero = (i_b == '0);
  // Divisor is forced to 1 when zero so the divider never sees 0; the
  // all-ones result below overrides the quotient in that case anyway.
  assign w_quot   = i_a / (w_b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : i_b);

  always_comb begin
    o_result = w_prod;
    o_div0   = 1'b0;
    if (i_op == OP_DIV) begin
      if (w_b_zero) begin
        o_result = '1;
        o_div0   = 1'b1;
      end else begin
        o_result = w_quot;
      end
    end
  end

endmodule

// File: rtl/muldiv_fu.sv
// -----------------------------------------------------------------------------
// muldiv_fu
// Multiply/divide functional unit between a reservation station and the CDB
// arbiter. Captures op, tag and operands on the issue handshake, waits the
// per-op latency, then holds a tagged result request until granted.
// Ports:
//   i_clk, i_srst          : clock, synchronous active-high reset
//   i_issue_valid/o_issue_ready, i_issue_op, i_issue_tag, i_opa, i_opb
//                          : issue handshake and operands
//   o_cdb_req, i_cdb_grant : CDB request / grant
//   o_cdb_tag, o_cdb_data, o_cdb_div0 : registered result
//   o_busy                 : an operation is held (EXEC or WAIT_CDB)
// -----------------------------------------------------------------------------
module muldiv_fu
  import tomasulo_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 4
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_issue_valid,
  output logic             o_issue_ready,
  input  logic             i_issue_op,
  input  logic [TAG_W-1:0] i_issue_tag,
  input  logic [WIDTH-1:0] i_opa,
  input  logic [WIDTH-1:0] i_opb,
  output logic             o_cdb_req,
  input  logic             i_cdb_grant,
  output logic [TAG_W-1:0] o_cdb_tag,
  output logic [WIDTH-1:0] o_cdb_data,
  output logic             o_cdb_div0,
  output logic             o_busy
);

  // Counter holds at most LAT-1, so clog2(max LAT) bits are enough.
  localparam int MAX_LAT = max_int(MUL_LAT, DIV_LAT);
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_op;
  logic [TAG_W-1:0] r_tag;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic             r_cdb_req;
  logic [TAG_W-1:0] r_cdb_tag;
  logic [WIDTH-1:0] r_cdb_data;
  logic             r_cdb_div0;

  logic             w_accept;
  logic             w_exec_done;
  logic             w_granted;
  logic [WIDTH-1:0] w_result;
  logic             w_div0;

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .i_op     (r_op),
    .i_a      (r_opa),
    .i_b      (r_opb),
    .o_result (w_result),
    .o_div0   (w_div0)
  );

  assign w_accept    = (r_state == ST_IDLE) && i_issue_valid;
  assign w_exec_done = (r_state == ST_EXEC) && (r_cnt == '0);
  // The request is high exactly in WAIT_CDB, so a grant seen elsewhere is
  // ignored by construction.
  assign w_granted   = (r_state == ST_WAIT_CDB) && i_cdb_grant;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (i_issue_valid) w_state_next = ST_EXEC;
      ST_EXEC:     if (r_cnt == '0)   w_state_next = ST_WAIT_CDB;
      ST_WAIT_CDB: if (i_cdb_grant)   w_state_next = ST_IDLE;
      default:                        w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_cnt      <= '0;
      r_op       <= OP_MUL;
      r_tag      <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_cdb_req  <= 1'b0;
      r_cdb_tag  <= '0;
      r_cdb_data <= '0;
      r_cdb_div0 <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= i_issue_op;
        r_tag <= i_issue_tag;
        r_opa <= i_opa;
        r_opb <= i_opb;
        // Loading LAT-1 and finishing on zero gives exactly LAT edges from
        // accept to the request appearing.
        r_cnt <= (i_issue_op == OP_DIV) ? CNT_W'(DIV_LAT - 1)
                                        : CNT_W'(MUL_LAT - 1);
      end else if ((r_state == ST_EXEC) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_exec_done) begin
        r_cdb_req  <= 1'b1;
        r_cdb_tag  <= r_tag;
        r_cdb_data <= w_result;
        r_cdb_div0 <= w_div0;
      end else if (w_granted) begin
        // Tag/data/div0 deliberately keep their last value after grant.
        r_cdb_req <= 1'b0;
      end
    end
  end

  assign o_issue_ready = (r_state == ST_IDLE);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_cdb_req     = r_cdb_req;
  assign o_cdb_tag     = r_cdb_tag;
  assign o_cdb_data    = r_cdb_data;
  assign o_cdb_div0    = r_cdb_div0;

endmodule

// File: tb/tb_muldiv_fu.sv
// -----------------------------------------------------------------------------
// tb_muldiv_fu
// Directed bench for muldiv_fu. Instance a uses default latencies (3/4),
// instance b uses MUL_LAT=1, DIV_LAT=8. Expected values are hand computed.
// -----------------------------------------------------------------------------
module tb_muldiv_fu;

  logic        clk;
  logic        srst;

  logic        a_valid, a_op, a_grant;
  logic [2:0]  a_tag;
  logic [15:0] a_opa, a_opb;
  logic        a_ready, a_req, a_div0, a_busy;
  logic [2:0]  a_ctag;
  logic [15:0] a_data;

  logic        b_valid, b_op, b_grant;
  logic [2:0]  b_tag;
  logic [15:0] b_opa, b_opb;
  logic        b_ready, b_req, b_div0, b_busy;
  logic [2:0]  b_ctag;
  logic [15:0] b_data;

  int n_cmp;
  int n_bad;

  muldiv_fu #(.WIDTH(16), .TAG_W(3), .MUL_LAT(3), .DIV_LAT(4)) u_dut_a (
    .i_clk(clk), .i_srst(srst),
    .i_issue_valid(a_valid), .o_issue_ready(a_ready), .i_issue_op(a_op),
    .i_issue_tag(a_tag), .i_opa(a_opa), .i_opb(a_opb),
    .o_cdb_req(a_req), .i_cdb_grant(a_grant), .o_cdb_tag(a_ctag),
    .o_cdb_data(a_data), .o_cdb_div0(a_div0), .o_busy(a_busy)
  );

  muldiv_fu #(.WIDTH(16), .TAG_W(3), .MUL_LAT(1), .DIV_LAT(8)) u_dut_b (
    .i_clk(clk), .i_srst(srst),
    .i_issue_valid(b_valid), .o_issue_ready(b_ready), .i_issue_op(b_op),
    .i_issue_tag(b_tag), .i_opa(b_opa), .i_opb(b_opb),
    .o_cdb_req(b_req), .i_cdb_grant(b_grant), .o_cdb_tag(b_ctag),
    .o_cdb_data(b_data), .o_cdb_div0(b_div0), .o_busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges from an accept until the unit A request appears (bounded).
  task automatic wait_req_a(output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n++;
      if (a_req) break;
    end
  endtask

  task automatic wait_req_b(output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n++;
      if (b_req) break;
    end
  endtask

  // Present an op to unit A and take the accept edge.
  task automatic issue_a(input logic op, input logic [15:0] x, input logic [15:0] y,
                         input logic [2:0] tag);
    a_valid = 1'b1; a_op = op; a_opa = x; a_opb = y; a_tag = tag;
    tick();
    a_valid = 1'b0;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    tick(); tick();
    srst = 1'b0;
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", a_ready); end
    n_cmp++; if (a_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", a_req); end
    n_cmp++; if (a_ctag !== 3'd0) begin n_bad++; $display("FAIL reset_tag: got %0d want 0", a_ctag); end
    n_cmp++; if (a_data !== 16'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0000", a_data); end
    n_cmp++; if (a_div0 !== 1'b0) begin n_bad++; $display("FAIL reset_div0: got %b want 0", a_div0); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL reset_b_ready: got %b want 1", b_ready); end
    $display("reset: ready=%b req=%b busy=%b", a_ready, a_req, a_busy);
  endtask

  task automatic test_mul_basic();
    int n;
    a_grant = 1'b1;
    issue_a(1'b0, 16'd7, 16'd6, 3'd2);
    n_cmp++; if (a_busy !== 1'b1 || a_ready !== 1'b0) begin n_bad++; $display("FAIL mul_busy: got busy=%b ready=%b want 1/0", a_busy, a_ready); end
    wait_req_a(n);
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL mul_latency: got %0d want 3", n); end
    n_cmp++; if (a_data !== 16'd42) begin n_bad++; $display("FAIL mul_data: got %0d want 42", a_data); end
    n_cmp++; if (a_ctag !== 3'd2) begin n_bad++; $display("FAIL mul_tag: got %0d want 2", a_ctag); end
    n_cmp++; if (a_div0 !== 1'b0) begin n_bad++; $display("FAIL mul_div0: got %b want 0", a_div0); end
    tick();
    n_cmp++; if (a_req !== 1'b0 || a_ready !== 1'b1) begin n_bad++; $display("FAIL mul_release: got req=%b ready=%b want 0/1", a_req, a_ready); end
    a_grant = 1'b0;
    $display("mul 7*6 tag2: lat=%0d data=%0d", n, a_data);
  endtask

  task automatic test_div_stall();
    int n;
    a_grant = 1'b0;
    issue_a(1'b1, 16'd100, 16'd7, 3'd5);
    wait_req_a(n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL div_latency: got %0d want 4", n); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (a_req !== 1'b1 || a_data !== 16'd14 || a_ctag !== 3'd5) begin
        n_bad++;
        $display("FAIL div_stall_hold: cycle %0d got req=%b data=%0d tag=%0d want 1/14/5", i, a_req, a_data, a_ctag);
      end
    end
    a_grant = 1'b1;
    tick();
    a_grant = 1'b0;
    n_cmp++; if (a_req !== 1'b0 || a_busy !== 1'b0 || a_ready !== 1'b1) begin n_bad++; $display("FAIL div_grant_clear: got req=%b busy=%b ready=%b want 0/0/1", a_req, a_busy, a_ready); end
    n_cmp++; if (a_data !== 16'd14) begin n_bad++; $display("FAIL div_data_after_grant: got %0d want 14", a_data); end
    $display("div 100/7 tag5: lat=%0d data=%0d stalled 4", n, a_data);
  endtask

  task automatic test_div0();
    int n;
    a_grant = 1'b1;
    issue_a(1'b1, 16'd9, 16'd0, 3'd1);
    wait_req_a(n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL div0_latency: got %0d want 4", n); end
    n_cmp++; if (a_data !== 16'hFFFF) begin n_bad++; $display("FAIL div0_data: got %h want ffff", a_data); end
    n_cmp++; if (a_div0 !== 1'b1) begin n_bad++; $display("FAIL div0_flag: got %b want 1", a_div0); end
    n_cmp++; if (a_ctag !== 3'd1) begin n_bad++; $display("FAIL div0_tag: got %0d want 1", a_ctag); end
    tick();
    a_grant = 1'b0;
    $display("div 9/0 tag1: lat=%0d data=%h div0=%b", n, a_data, a_div0);
  endtask

  task automatic test_trunc_capture();
    int n;
    a_grant = 1'b1;
    issue_a(1'b0, 16'hFFFF, 16'd2, 3'd3);
    // Operands change right after accept; the captured ones must be used.
    a_opa = 16'd5; a_opb = 16'd5;
    wait_req_a(n);
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL trunc_latency: got %0d want 3", n); end
    n_cmp++; if (a_data !== 16'hFFFE) begin n_bad++; $display("FAIL trunc_data: got %h want fffe", a_data); end
    n_cmp++; if (a_div0 !== 1'b0) begin n_bad++; $display("FAIL trunc_div0: got %b want 0", a_div0); end
    tick();
    a_grant = 1'b0;
    $display("mul ffff*2 tag3: lat=%0d data=%h", n, a_data);
  endtask

  task automatic test_issue_blocked();
    int n;
    a_grant = 1'b0;
    issue_a(1'b0, 16'd3, 16'd4, 3'd6);
    // Second op is presented and held while the first is in flight.
    a_valid = 1'b1; a_op = 1'b1; a_opa = 16'd50; a_opb = 16'd5; a_tag = 3'd7;
    n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL blocked_ready_exec: got %b want 0", a_ready); end
    wait_req_a(n);
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL blocked_latency: got %0d want 3", n); end
    n_cmp++; if (a_data !== 16'd12 || a_ctag !== 3'd6) begin n_bad++; $display("FAIL blocked_first: got data=%0d tag=%0d want 12/6", a_data, a_ctag); end
    tick();
    n_cmp++; if (a_ready !== 1'b0 || a_req !== 1'b1) begin n_bad++; $display("FAIL blocked_wait: got ready=%b req=%b want 0/1", a_ready, a_req); end
    a_grant = 1'b1;
    tick();
    a_grant = 1'b0;
    n_cmp++; if (a_ready !== 1'b1 || a_req !== 1'b0) begin n_bad++; $display("FAIL blocked_after_grant: got ready=%b req=%b want 1/0", a_ready, a_req); end
    tick();
    a_valid = 1'b0;
    n_cmp++; if (a_busy !== 1'b1) begin n_bad++; $display("FAIL blocked_second_accept: got busy=%b want 1", a_busy); end
    wait_req_a(n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL blocked_second_latency: got %0d want 4", n); end
    n_cmp++; if (a_data !== 16'd10 || a_ctag !== 3'd7) begin n_bad++; $display("FAIL blocked_second: got data=%0d tag=%0d want 10/7", a_data, a_ctag); end
    a_grant = 1'b1;
    tick();
    a_grant = 1'b0;
    $display("back_to_back: mul 3*4 tag6 then div 50/5 tag7 -> %0d", a_data);
  endtask

  task automatic test_reset_mid();
    logic seen;
    a_grant = 1'b1;
    issue_a(1'b1, 16'd20, 16'd4, 3'd4);
    tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    n_cmp++; if (a_ready !== 1'b1 || a_busy !== 1'b0 || a_req !== 1'b0) begin n_bad++; $display("FAIL reset_mid_state: got ready=%b busy=%b req=%b want 1/0/0", a_ready, a_busy, a_req); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (a_req) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL reset_mid_no_req: got %b want 0", seen); end
    a_grant = 1'b0;
    $display("reset in EXEC of div 20/4: abandoned, ready=%b", a_ready);
  endtask

  task automatic test_param_latency();
    int n;
    b_grant = 1'b1;
    b_valid = 1'b1; b_op = 1'b0; b_opa = 16'd5; b_opb = 16'd5; b_tag = 3'd1;
    tick();
    b_valid = 1'b0;
    wait_req_b(n);
    n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL lat1_mul_latency: got %0d want 1", n); end
    n_cmp++; if (b_data !== 16'd25 || b_ctag !== 3'd1) begin n_bad++; $display("FAIL lat1_mul_data: got data=%0d tag=%0d want 25/1", b_data, b_ctag); end
    tick();
    b_valid = 1'b1; b_op = 1'b1; b_opa = 16'd80; b_opb = 16'd3; b_tag = 3'd2;
    tick();
    b_valid = 1'b0;
    wait_req_b(n);
    n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL lat8_div_latency: got %0d want 8", n); end
    n_cmp++; if (b_data !== 16'd26 || b_ctag !== 3'd2) begin n_bad++; $display("FAIL lat8_div_data: got data=%0d tag=%0d want 26/2", b_data, b_ctag); end
    tick();
    n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL lat8_release: got %b want 1", b_ready); end
    b_grant = 1'b0;
    $display("param MUL_LAT=1 DIV_LAT=8: div 80/3 -> %0d", b_data);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    srst = 1'b1;
    a_valid = 1'b0; a_op = 1'b0; a_tag = '0; a_opa = '0; a_opb = '0; a_grant = 1'b0;
    b_valid = 1'b0; b_op = 1'b0; b_tag = '0; b_opa = '0; b_opb = '0; b_grant = 1'b0;
    test_reset();
    test_mul_basic();
    test_div_stall();
    test_div0();
    test_trunc_capture();
    test_issue_blocked();
    test_reset_mid();
    test_param_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_fu.md
Name: muldiv_fu

Overview:
- Parametrised multiply/divide functional unit for the Tomasulo datapath.
- Sits between its reservation station and the CDB arbiter.
- Accepts one operation per issue handshake and captures operands and the destination tag at issue.
- Runs for a configurable per-op latency, then holds the tagged result on a CDB request until the arbiter grants it.

Parameters:
- WIDTH, 16, operand and result width in bits.
- TAG_W, 3, reservation-station tag width.
- MUL_LAT, 3, cycles from issue accept to cdb_req for multiply (>=1).
- DIV_LAT, 4, cycles from issue accept to cdb_req for divide (>=1).

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  reservation station presents an operation.
- issue_ready  out  1  unit can accept an operation this cycle.
- issue_op  in  1  0 = multiply, 1 = divide.
- issue_tag  in  TAG_W  destination tag.
- opa  in  WIDTH  operand A (dividend).
- opb  in  WIDTH  operand B (divisor).
- cdb_req  out  1  result valid, requesting the CDB.
- cdb_grant  in  1  arbiter grants the CDB this cycle.
- cdb_tag  out  TAG_W  tag of the result.
- cdb_data  out  WIDTH  result value.
- cdb_div0  out  1  result came from a divide by zero.
- busy  out  1  an operation is held (EXEC or WAIT_CDB).

Behaviour:
- Reset (synchronous, when Reset=1 at a rising edge):
  - state=IDLE, counter=0.
  - cdb_req=0, cdb_tag=0, cdb_data=0, cdb_div0=0, busy=0, issue_ready=1 (combinational from state).
  - Reset mid-operation abandons the operation; no CDB request is ever made for it.
- FSM states: IDLE, EXEC, WAIT_CDB. issue_ready = (state==IDLE).
- IDLE:
  - On issue_valid & issue_ready, register op, tag, opa, opb.
  - Load the counter with (op ? DIV_LAT : MUL_LAT) - 1 and go to EXEC.
- EXEC:
  - Decrement the counter each cycle.
  - When counter==0, register the result into cdb_data/cdb_tag/cdb_div0, set cdb_req=1 and go to WAIT_CDB.
- Timing: an accept at edge T gives cdb_req=1 after edge T+LAT, i.e. exactly LAT cycles later.
- LAT=1 is legal: EXEC lasts one cycle.
- WAIT_CDB:
  - Hold cdb_req, cdb_tag, cdb_data and cdb_div0 stable until cdb_grant=1.
  - On grant, clear cdb_req at that edge and go to IDLE.
  - issue_ready rises the following cycle. There is no same-cycle grant-and-issue bypass.
- cdb_grant while cdb_req=0 is ignored.
- issue_valid while issue_ready=0 is ignored. The reservation station must hold the request.
- Operand changes after accept have no effect, because operands are captured at issue.
- Arithmetic, unsigned:
  - Multiply gives the low WIDTH bits of opa*opb, with overflow truncated.
  - Divide gives the truncating quotient opa/opb.
- Divide by zero (opb==0, op=1): cdb_data = all ones, cdb_div0=1. Latency is still DIV_LAT.
- cdb_div0 is always 0 for multiply.
- cdb_data and cdb_tag keep their last value after grant. They are only meaningful while cdb_req=1.
- busy = (state!=IDLE).

Decomposition:
- Shared package tomasulo_pkg:
  - OP_MUL=1'b0, OP_DIV=1'b1.
  - Default WIDTH and TAG_W constants.
  - FSM state encoding localparams.
- One natural sub-module, muldiv_core: combinational WIDTH-parametrised mul/div.
  - Outputs result and div0.
  - Lets a pipelined or iterative core replace it later without touching the handshake FSM.

Test Plan:
- Reset, then issue MUL opa=7 opb=6 tag=2 with grant tied high -> cdb_req high exactly 3 cycles after accept, cdb_data=42, cdb_tag=2, cdb_div0=0, then issue_ready=1 the next cycle.
- Issue DIV opa=100 opb=7 tag=5 with grant held low 4 cycles -> cdb_req at +4 cycles, data=14 and tag=5 stable through the stall, cleared on the grant edge.
- Issue DIV opa=9 opb=0 -> cdb_data=16'hFFFF, cdb_div0=1, latency 4.
- Issue MUL 16'hFFFF*2 -> cdb_data=16'hFFFE (truncated). Change opa/opb one cycle after accept -> result unaffected.
- Assert issue_valid during EXEC -> not accepted (issue_ready=0); accepted the cycle after the previous grant.
- Reset asserted in EXEC of DIV -> next cycle state IDLE, cdb_req never asserts, issue_ready=1. Also re-run with MUL_LAT=1, DIV_LAT=8 to check parametrised latency.
